// File: rtl/tcp_mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tcp_mem_rr_arbiter
//
// Grants one of DEVICE_NUM TCP controllers exclusive use of the shared
// unconfirmed-memory write port. The grant is held until the granted channel
// pulses done_i or the grant watchdog expires. Two arbitration policies:
//   MODE 0 : legacy descending sweep (highest eligible index below a mask)
//   MODE 1 : rotating round-robin (first eligible index after the last winner)
//
// Handshake: a channel is eligible while its registered request and its
// enable are both high. A new grant is issued only from IDLE while
// wr_allow_i is high. Once issued, the grant cannot be revoked by dropping
// the request or enable; it ends on done_i (single-cycle pulse), on watchdog
// expiry, on flush_i or on reset. Every grant is followed by one RELEASE
// cycle with no grant.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   req_i        per-channel request level
//   en_i         per-channel enable
//   wr_allow_i   end controller ready, sampled only in IDLE
//   done_i       end-of-transfer pulse from the granted channel
//   flush_i      synchronous clear of arbitration state (top priority)
//   gnt_o        one-hot grant (registered)
//   gnt_vld_o    grant valid, equals |gnt_o (registered)
//   gnt_port_o   index of the current or last granted channel
//   busy_o       high while in GRANT or RELEASE
//   timeout_o    one-cycle pulse in the RELEASE cycle after a watchdog expiry
// ---------------------------------------------------------------------------
module tcp_mem_rr_arbiter #(
    parameter  int DEVICE_NUM    = 4,
    parameter  int MODE          = 1,
    parameter  int MAX_GRANT_CYC = 256,
    localparam int PORT_W        = (DEVICE_NUM > 1) ? $clog2(DEVICE_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DEVICE_NUM-1:0] req_i,
    input  logic [DEVICE_NUM-1:0] en_i,
    input  logic                  wr_allow_i,
    input  logic                  done_i,
    input  logic                  flush_i,
    output logic [DEVICE_NUM-1:0] gnt_o,
    output logic                  gnt_vld_o,
    output logic [PORT_W-1:0]     gnt_port_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    // Grant age counter width; must be able to hold MAX_GRANT_CYC.
    localparam int CNT_W = (MAX_GRANT_CYC > 0) ? $clog2(MAX_GRANT_CYC + 1) : 1;

    // Watchdog fires when the age reaches MAX_GRANT_CYC-1, i.e. after the
    // grant has been visible for exactly MAX_GRANT_CYC cycles.
    localparam bit               WDOG_EN  = (MAX_GRANT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_GRANT_CYC > 0) ? (MAX_GRANT_CYC - 1) : 0);

    // The sweep mask must be able to hold DEVICE_NUM itself ("nothing
    // excluded"), so it is one bit wider than a port index.
    localparam logic [PORT_W:0]   MASK_INIT = (PORT_W + 1)'(DEVICE_NUM);
    localparam logic [PORT_W-1:0] LAST_INIT = PORT_W'(DEVICE_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [DEVICE_NUM-1:0] r_req;
    logic [DEVICE_NUM-1:0] r_gnt;
    logic                  r_gnt_vld;
    logic [PORT_W-1:0]     r_gnt_port;
    logic                  r_busy;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_cnt;
    logic [PORT_W:0]       r_mask;
    logic [PORT_W-1:0]     r_last;

    // ------------------------------------------------------------------
    // Combinational winner selection
    // ------------------------------------------------------------------
    logic [DEVICE_NUM-1:0] w_elig;

    // Round-robin: lowest eligible index strictly above r_last, falling
    // back to the lowest eligible index overall (the wrap-around case).
    logic                  w_rr_hi_found;
    logic [PORT_W-1:0]     w_rr_hi_idx;
    logic                  w_rr_lo_found;
    logic [PORT_W-1:0]     w_rr_lo_idx;
    logic                  w_rr_found;
    logic [PORT_W-1:0]     w_rr_idx;

    // Descending sweep: highest eligible index strictly below r_mask.
    logic                  w_sw_found;
    logic [PORT_W-1:0]     w_sw_idx;

    logic                  w_win_found;
    logic [PORT_W-1:0]     w_win_idx;
    logic [DEVICE_NUM-1:0] w_win_onehot;
    logic [PORT_W:0]       w_next_mask;
    logic                  w_any_elig;
    logic                  w_expire;

    assign w_elig     = r_req & en_i;
    assign w_any_elig = |w_elig;

    always_comb begin
        w_rr_hi_found = 1'b0;
        w_rr_hi_idx   = '0;
        w_rr_lo_found = 1'b0;
        w_rr_lo_idx   = '0;
        // Descending loops: the final assignment is the lowest match.
        for (int i = DEVICE_NUM - 1; i >= 0; i--) begin
            if (w_elig[PORT_W'(i)]) begin
                w_rr_lo_found = 1'b1;
                w_rr_lo_idx   = PORT_W'(i);
            end
            if (w_elig[PORT_W'(i)] && (PORT_W'(i) > r_last)) begin
                w_rr_hi_found = 1'b1;
                w_rr_hi_idx   = PORT_W'(i);
            end
        end
        w_rr_found = w_rr_hi_found | w_rr_lo_found;
        w_rr_idx   = w_rr_hi_found ? w_rr_hi_idx : w_rr_lo_idx;
    end

    always_comb begin
        w_sw_found = 1'b0;
        w_sw_idx   = '0;
        // Ascending loop: the final assignment is the highest match.
        for (int i = 0; i < DEVICE_NUM; i++) begin
            if (w_elig[PORT_W'(i)] && ((PORT_W + 1)'(i) < r_mask)) begin
                w_sw_found = 1'b1;
                w_sw_idx   = PORT_W'(i);
            end
        end
    end

    always_comb begin
        if (MODE == 1) begin
            w_win_found = w_rr_found;
            w_win_idx   = w_rr_idx;
        end else begin
            w_win_found = w_sw_found;
            w_win_idx   = w_sw_idx;
        end
        w_win_onehot = DEVICE_NUM'(1) << w_win_idx;
        // After granting index 0 the sweep restarts from the top.
        w_next_mask  = (w_win_idx == '0) ? MASK_INIT : {1'b0, w_win_idx};
    end

    assign w_expire = WDOG_EN && (r_cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // Arbitration FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req      <= '0;
            r_gnt      <= '0;
            r_gnt_vld  <= 1'b0;
            r_gnt_port <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= '0;
            r_mask     <= MASK_INIT;
            r_last     <= LAST_INIT;
        end else begin
            r_req     <= req_i;
            r_timeout <= 1'b0;

            if (flush_i) begin
                // gnt_port_o deliberately keeps the last granted index.
                r_state   <= ST_IDLE;
                r_gnt     <= '0;
                r_gnt_vld <= 1'b0;
                r_busy    <= 1'b0;
                r_cnt     <= '0;
                r_mask    <= MASK_INIT;
                r_last    <= LAST_INIT;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (wr_allow_i && w_any_elig) begin
                            if (w_win_found) begin
                                r_state    <= ST_GRANT;
                                r_gnt      <= w_win_onehot;
                                r_gnt_vld  <= 1'b1;
                                r_gnt_port <= w_win_idx;
                                r_busy     <= 1'b1;
                                r_cnt      <= '0;
                                r_last     <= w_win_idx;
                                r_mask     <= w_next_mask;
                            end else begin
                                // Sweep exhausted below the mask: wrap, and
                                // grant on a later cycle.
                                r_mask <= MASK_INIT;
                            end
                        end
                    end

                    ST_GRANT: begin
                        if (done_i) begin
                            // done has priority over a simultaneous expiry.
                            r_state   <= ST_RELEASE;
                            r_gnt     <= '0;
                            r_gnt_vld <= 1'b0;
                        end else if (w_expire) begin
                            r_state   <= ST_RELEASE;
                            r_gnt     <= '0;
                            r_gnt_vld <= 1'b0;
                            r_timeout <= 1'b1;
                        end else if (r_cnt != '1) begin
                            // Saturating: matters only with the watchdog off.
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    ST_RELEASE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end

                    default: begin
                        r_state   <= ST_IDLE;
                        r_gnt     <= '0;
                        r_gnt_vld <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign gnt_o      = r_gnt;
    assign gnt_vld_o  = r_gnt_vld;
    assign gnt_port_o = r_gnt_port;
    assign busy_o     = r_busy;
    assign timeout_o  = r_timeout;

endmodule

// File: tb/tb_tcp_mem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for tcp_mem_rr_arbiter. Two instances (sweep and round-robin, both
// with an 8-cycle watchdog) share the same stimulus. A behavioural model of
// both arbitration policies predicts every output; one compare process
// checks the DUTs against it at each falling edge. Directed sequences pin
// the model with hand-derived literal expectations, then a random phase
// exercises mixed traffic.
// ---------------------------------------------------------------------------
module tb_tcp_mem_rr_arbiter;

    localparam int N    = 4;
    localparam int MAXC = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] req      = '0;
    logic [N-1:0] en       = '0;
    logic         wr_allow = 1'b0;
    logic         done     = 1'b0;
    logic         flush    = 1'b0;

    logic [N-1:0] gnt0, gnt1;
    logic         vld0, vld1, busy0, busy1, to0, to1;
    logic [1:0]   port0, port1;

    tcp_mem_rr_arbiter #(.DEVICE_NUM(N), .MODE(0), .MAX_GRANT_CYC(MAXC)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .en_i(en), .wr_allow_i(wr_allow),
        .done_i(done), .flush_i(flush), .gnt_o(gnt0), .gnt_vld_o(vld0),
        .gnt_port_o(port0), .busy_o(busy0), .timeout_o(to0)
    );

    tcp_mem_rr_arbiter #(.DEVICE_NUM(N), .MODE(1), .MAX_GRANT_CYC(MAXC)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .en_i(en), .wr_allow_i(wr_allow),
        .done_i(done), .flush_i(flush), .gnt_o(gnt1), .gnt_vld_o(vld1),
        .gnt_port_o(port1), .busy_o(busy1), .timeout_o(to1)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 models the sweep instance, index 1 the round-robin instance.
    // phase: 0 = idle, 1 = granted, 2 = one dead cycle after a grant.
    int           m_phase [2];
    int           m_last  [2];
    int           m_mask  [2];
    int           m_age   [2];
    logic [N-1:0] m_req_r;
    logic [N-1:0] e_gnt   [2];
    int           e_port  [2];
    bit           e_busy  [2];
    bit           e_to    [2];

    function automatic int pick(input int u, input logic [N-1:0] elig);
        if (u == 1) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last[u] + k) % N;
                if (elig[idx]) return idx;
            end
        end else begin
            for (int i = m_mask[u] - 1; i >= 0; i--)
                if (elig[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_phase[u] = 0;
            m_last[u]  = N - 1;
            m_mask[u]  = N;
            m_age[u]   = 0;
            e_gnt[u]   = '0;
            e_port[u]  = 0;
            e_busy[u]  = 1'b0;
            e_to[u]    = 1'b0;
        end
        m_req_r = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] elig;
        int w;
        elig = m_req_r & en;
        for (int u = 0; u < 2; u++) begin
            e_to[u] = 1'b0;
            if (flush) begin
                m_phase[u] = 0;
                e_gnt[u]   = '0;
                e_busy[u]  = 1'b0;
                m_age[u]   = 0;
                m_mask[u]  = N;
                m_last[u]  = N - 1;
            end else if (m_phase[u] == 0) begin
                if (wr_allow && elig != 0) begin
                    w = pick(u, elig);
                    if (w >= 0) begin
                        m_phase[u] = 1;
                        e_gnt[u]   = N'(1) << w;
                        e_port[u]  = w;
                        e_busy[u]  = 1'b1;
                        m_age[u]   = 0;
                        m_last[u]  = w;
                        m_mask[u]  = (w == 0) ? N : w;
                    end else begin
                        m_mask[u] = N;
                    end
                end
            end else if (m_phase[u] == 1) begin
                if (done) begin
                    m_phase[u] = 2;
                    e_gnt[u]   = '0;
                end else if (m_age[u] == MAXC - 1) begin
                    m_phase[u] = 2;
                    e_gnt[u]   = '0;
                    e_to[u]    = 1'b1;
                end else begin
                    m_age[u]++;
                end
            end else begin
                m_phase[u] = 0;
                e_busy[u]  = 1'b0;
            end
        end
        m_req_r = req;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (check_en && rst_n) begin
                for (int u = 0; u < 2; u++) begin
                    chk($sformatf("m%0d_gnt", u),  32'(u == 0 ? gnt0  : gnt1),  32'(e_gnt[u]));
                    chk($sformatf("m%0d_vld", u),  32'(u == 0 ? vld0  : vld1),  32'(e_gnt[u] != '0));
                    chk($sformatf("m%0d_port", u), 32'(u == 0 ? port0 : port1), 32'(e_port[u]));
                    chk($sformatf("m%0d_busy", u), 32'(u == 0 ? busy0 : busy1), 32'(e_busy[u]));
                    chk($sformatf("m%0d_to", u),   32'(u == 0 ? to0   : to1),   32'(e_to[u]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        done  = 1'b0;
        flush = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for the round-robin instance to show a grant; gap is
    // the number of falling edges seen without a grant.
    task automatic wait_grant(output int gap, output bit ok);
        gap = 0;
        ok  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (vld1) begin
                ok = 1'b1;
                break;
            end
            gap++;
            tick(1);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_grant: no grant within 30 cycles (t=%0t)", $time);
        end
    endtask

    task automatic pulse_done_after(input int n);
        tick(n);
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    int seq_rr[5] = '{0, 1, 2, 3, 0};
    int seq_sw[5] = '{3, 2, 1, 0, 3};
    int seq_c [4] = '{0, 2, 0, 2};

    initial begin
        int gap;
        bit ok;
        int len;
        int zc;

        // ---- A: all requesting, done 3 cycles after each grant ----
        req = 4'b1111; en = 4'b1111; wr_allow = 1'b1;
        do_reset();
        check_en = 1'b1;
        chk("rst_gnt0", 32'(gnt0), 32'(0));
        chk("rst_gnt1", 32'(gnt1), 32'(0));
        chk("rst_vld1", 32'(vld1), 32'(0));
        chk("rst_port1", 32'(port1), 32'(0));
        chk("rst_busy1", 32'(busy1), 32'(0));
        chk("rst_to1", 32'(to1), 32'(0));
        for (int g = 0; g < 5; g++) begin
            wait_grant(gap, ok);
            if (!ok) break;
            chk("A_port_rr", 32'(port1), 32'(seq_rr[g]));
            chk("A_port_sw", 32'(port0), 32'(seq_sw[g]));
            if (g > 0) chk("A_gap", 32'(gap), 32'(2));
            pulse_done_after(3);
        end

        // ---- B: watchdog, then done coinciding with expiry ----
        req = 4'b0011; en = 4'b1111; wr_allow = 1'b1;
        do_reset();
        wait_grant(gap, ok);
        chk("B_first_gnt", 32'(gnt1), 32'(4'b0001));
        len = 0;
        while (gnt1 == 4'b0001 && len < 20) begin
            len++;
            tick(1);
        end
        chk("B_len", 32'(len), 32'(8));
        chk("B_timeout", 32'(to1), 32'(1));
        tick(1);
        chk("B_timeout_once", 32'(to1), 32'(0));
        wait_grant(gap, ok);
        chk("B_second_gnt", 32'(gnt1), 32'(4'b0010));
        tick(7);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        chk("B_done_wins_to", 32'(to1), 32'(0));
        chk("B_done_wins_gnt", 32'(gnt1), 32'(0));

        // ---- C: enable mask, enable dropped mid-grant ----
        req = 4'b1111; en = 4'b0101; wr_allow = 1'b1;
        do_reset();
        for (int g = 0; g < 4; g++) begin
            wait_grant(gap, ok);
            if (!ok) break;
            chk("C_port", 32'(port1), 32'(seq_c[g]));
            if (g == 2) begin
                tick(1);
                en = 4'b0100;
                tick(1);
                chk("C_hold", 32'(gnt1), 32'(4'b0001));
                tick(1);
                done = 1'b1;
                tick(1);
                done = 1'b0;
                chk("C_released", 32'(gnt1), 32'(0));
                en = 4'b0101;
            end else begin
                pulse_done_after(3);
            end
        end

        // ---- D: wr_allow gating ----
        req = 4'b0100; en = 4'b1111; wr_allow = 1'b0;
        do_reset();
        zc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (gnt1 == '0 && gnt0 == '0) zc++;
        end
        chk("D_held_off", 32'(zc), 32'(20));
        wr_allow = 1'b1;
        tick(1);
        chk("D_grant_rr", 32'(gnt1), 32'(4'b0100));
        chk("D_grant_sw", 32'(gnt0), 32'(4'b0100));

        // ---- E: flush mid-grant on port 2 ----
        tick(1);
        flush = 1'b1;
        req   = 4'b1111;
        tick(1);
        flush = 1'b0;
        chk("E_gnt", 32'(gnt1), 32'(0));
        chk("E_to", 32'(to1), 32'(0));
        chk("E_port_kept", 32'(port1), 32'(2));
        wait_grant(gap, ok);
        chk("E_next_port", 32'(port1), 32'(0));

        // ---- F: asynchronous reset mid-grant ----
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("F_gnt0", 32'(gnt0), 32'(0));
        chk("F_gnt1", 32'(gnt1), 32'(0));
        chk("F_vld1", 32'(vld1), 32'(0));
        chk("F_port1", 32'(port1), 32'(0));
        chk("F_busy1", 32'(busy1), 32'(0));
        chk("F_to1", 32'(to1), 32'(0));
        tick(2);
        rst_n = 1'b1;

        // ---- random traffic ----
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            req      = N'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : 4'b1111;
            wr_allow = ($urandom_range(0, 7) != 0);
            done     = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 60) == 0);
        end
        tick(1);
        done  = 1'b0;
        flush = 1'b0;
        tick(2);
        check_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
